// File: rtl/target_generator.sv
// Food-target generator: rejection-samples the X/Y LFSR words into an in-bounds grid
// coordinate. Optional macro TARGET_GEN_AVOID_HEAD_EN rejects candidates on the snake head.
module target_generator #(
   parameter int X_WIDTH   = 8,
   parameter int Y_WIDTH   = 7,
   parameter int X_MAX     = 159,
   parameter int Y_MAX     = 119,
   parameter int INIT_X    = 20,
   parameter int INIT_Y    = 15,
   parameter int MAX_TRIES = 8
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [X_WIDTH-1:0] X_RAND,
   input  logic [Y_WIDTH-1:0] Y_RAND,
   input  logic               REACHED,
   input  logic [X_WIDTH-1:0] HEAD_X,
   input  logic [Y_WIDTH-1:0] HEAD_Y,
   output logic [X_WIDTH-1:0] TARGET_X,
   output logic [Y_WIDTH-1:0] TARGET_Y,
   output logic               TARGET_VALID,
   output logic [7:0]         TARGET_COUNT
);

   localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

   localparam logic [X_WIDTH-1:0] X_LIM    = X_WIDTH'(X_MAX);
   localparam logic [Y_WIDTH-1:0] Y_LIM    = Y_WIDTH'(Y_MAX);
   localparam logic [X_WIDTH-1:0] X_INIT   = X_WIDTH'(INIT_X);
   localparam logic [Y_WIDTH-1:0] Y_INIT   = Y_WIDTH'(INIT_Y);
   localparam logic [TRY_W-1:0]   LAST_TRY = TRY_W'(MAX_TRIES - 1);

   typedef enum logic {
      IDLE   = 1'b0,
      SEARCH = 1'b1
   } state_t;

   state_t             state, state_n;
   logic [TRY_W-1:0]   try_cnt, try_n;
   logic [X_WIDTH-1:0] tgt_x_p0, new_x;
   logic [Y_WIDTH-1:0] tgt_y_p0, new_y;
   logic               vld_p0;
   logic [7:0]         count_p0;
   logic               in_range, on_head, cand_ok, done;

   // The word range is at most twice the grid, so a single subtraction always lands in range.
   function automatic logic [X_WIDTH-1:0] fold_x(input logic [X_WIDTH-1:0] v);
      if (v > X_LIM)
         fold_x = v - X_LIM - X_WIDTH'(1);
      else
         fold_x = v;
   endfunction

   function automatic logic [Y_WIDTH-1:0] fold_y(input logic [Y_WIDTH-1:0] v);
      if (v > Y_LIM)
         fold_y = v - Y_LIM - Y_WIDTH'(1);
      else
         fold_y = v;
   endfunction

   assign in_range = (X_RAND <= X_LIM) && (Y_RAND <= Y_LIM);

`ifdef TARGET_GEN_AVOID_HEAD_EN
   assign on_head = (X_RAND == HEAD_X) && (Y_RAND == HEAD_Y);
`else
   logic unused_head;
   assign unused_head = ^{HEAD_X, HEAD_Y};
   assign on_head     = 1'b0;
`endif

   assign cand_ok = in_range && !on_head;

   always_comb begin
      state_n = state;
      try_n   = try_cnt;
      done    = 1'b0;
      new_x   = X_RAND;
      new_y   = Y_RAND;
      case (state)
         IDLE: begin
            if (REACHED) begin
               state_n = SEARCH;
               try_n   = '0;
            end
         end
         SEARCH: begin
            if (cand_ok) begin
               done    = 1'b1;
               state_n = IDLE;
            end else if (try_cnt == LAST_TRY) begin
               // Out of tries: fold the current words into the grid, no head check.
               done    = 1'b1;
               new_x   = fold_x(X_RAND);
               new_y   = fold_y(Y_RAND);
               state_n = IDLE;
            end else begin
               try_n = try_cnt + TRY_W'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= IDLE;
         try_cnt  <= '0;
         tgt_x_p0 <= X_INIT;
         tgt_y_p0 <= Y_INIT;
         vld_p0   <= 1'b1;
         count_p0 <= 8'd0;
      end else begin
         state   <= state_n;
         try_cnt <= try_n;
         if (state == IDLE && REACHED)
            vld_p0 <= 1'b0;
         if (done) begin
            tgt_x_p0 <= new_x;
            tgt_y_p0 <= new_y;
            vld_p0   <= 1'b1;
            count_p0 <= count_p0 + 8'd1;
         end
      end
   end

   assign TARGET_X     = tgt_x_p0;
   assign TARGET_Y     = tgt_y_p0;
   assign TARGET_VALID = vld_p0;
   assign TARGET_COUNT = count_p0;

endmodule
